// File: rtl/fir_package.sv
// Shared types for the FIR tap serializer.
// Holds the FSM state enum and a counter sizing helper.
package fir_package;

  typedef enum logic {
    IDLE      = 1'b0,
    SERIALIZE = 1'b1
  } fir_ser_state_t;

  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream interface with byte strobes.
// The source drives valid/data/strb, the sink drives ready.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic clk
);

  localparam int unsigned STRB_WIDTH =
    (DATA_WIDTH >= 8) ? DATA_WIDTH / 8 : 1;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (
    output valid, data, strb,
    input  ready
  );

  modport sink (
    input  valid, data, strb,
    output ready
  );

endinterface

// File: rtl/fir_tap_serializer.sv
// Serializes a packed beat of NB_TAPS words onto a word stream,
// word 0 first, reloading on the last word for zero-bubble streaming.
module fir_tap_serializer
  import fir_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NB_TAPS    = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  hwpe_stream_intf_stream.sink   h_parallel,
  hwpe_stream_intf_stream.source h_serial,
  output logic last_o
);

  localparam int unsigned CW = cnt_width(NB_TAPS);
  localparam int unsigned BW = DATA_WIDTH * NB_TAPS;
  localparam logic [CW-1:0] LAST = CW'(NB_TAPS - 1);

  fir_ser_state_t  state_q;
  logic [CW-1:0]   cnt_q;
  logic [BW-1:0]   buf_q;

  logic is_last;
  logic ser_hs;
  logic par_hs;

  assign is_last = (cnt_q == LAST);
  assign ser_hs  = h_serial.valid & h_serial.ready;
  assign par_hs  = h_parallel.valid & h_parallel.ready;

  // The only combinational path: ready through on the last word.
  always_comb begin
    h_parallel.ready = 1'b1;
    if (state_q == SERIALIZE) begin
      h_parallel.ready = h_serial.ready & is_last;
    end
  end

  assign h_serial.valid = (state_q == SERIALIZE);
  assign h_serial.data  =
    buf_q[int'(cnt_q) * DATA_WIDTH +: DATA_WIDTH];
  assign h_serial.strb  = '1;
  assign last_o         = h_serial.valid & is_last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else if (clear_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (par_hs) begin
            buf_q   <= h_parallel.data;
            cnt_q   <= '0;
            state_q <= SERIALIZE;
          end
        end
        SERIALIZE: begin
          if (ser_hs) begin
            if (!is_last) begin
              cnt_q <= cnt_q + 1'b1;
            end else if (par_hs) begin
              buf_q <= h_parallel.data;
              cnt_q <= '0;
            end else begin
              cnt_q   <= '0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    assert (h_parallel.DATA_WIDTH == BW)
      else $error("h_parallel width does not match taps");
    assert (h_serial.DATA_WIDTH == DATA_WIDTH)
      else $error("h_serial width does not match word");
  end
`endif

endmodule

// File: tb/tb_fir_tap_serializer.sv
// Bench for fir_tap_serializer: 4-tap and 1-tap instances
// checked every cycle against a queue-of-words reference model.
module tb_fir_tap_serializer;

  localparam int DW = 32;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } wrd_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic clear = 1'b0;
  logic srdy = 1'b1;
  logic last4, last1;

  always #5 clk = ~clk;

  hwpe_stream_intf_stream #(.DATA_WIDTH(4*DW)) p4 (.clk(clk));
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW))   s4 (.clk(clk));
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW))   p1 (.clk(clk));
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW))   s1 (.clk(clk));

  assign s4.ready = srdy;
  assign s1.ready = srdy;

  fir_tap_serializer #(.DATA_WIDTH(DW), .NB_TAPS(4)) u_dut4 (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .clear_i    (clear),
    .h_parallel (p4),
    .h_serial   (s4),
    .last_o     (last4)
  );

  fir_tap_serializer #(.DATA_WIDTH(DW), .NB_TAPS(1)) u_dut1 (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .clear_i    (clear),
    .h_parallel (p1),
    .h_serial   (s1),
    .last_o     (last1)
  );

  int checks = 0;
  int errors = 0;

  wrd_t q4[$];
  wrd_t q1[$];
  logic [4*DW-1:0] pb4[$];
  logic [DW-1:0]   pb1[$];
  bit rpat[$];
  bit rnd_rdy = 1'b0;
  bit acc4, acc1;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit head_last(wrd_t q[$]);
    return (q.size() != 0) ? q[0].l : 1'b0;
  endfunction

  task automatic check_reset_outs();
    check("rst.s4.valid", s4.valid, 0);
    check("rst.last4", last4, 0);
    check("rst.s4.data", s4.data, 0);
    check("rst.s1.valid", s1.valid, 0);
    check("rst.last1", last1, 0);
    check("rst.s1.data", s1.data, 0);
  endtask

  // One clock cycle: inputs already set at the falling edge.
  task automatic step();
    bit r4, r1, h4, h1, a4, a1;
    logic [4*DW-1:0] beat;
    #1;
    r4 = (q4.size() == 0) || (q4.size() == 1 && srdy);
    r1 = (q1.size() == 0) || (q1.size() == 1 && srdy);
    check("s4.valid", s4.valid, q4.size() != 0);
    check("last4", last4, head_last(q4));
    if (q4.size() != 0) check("s4.data", s4.data, q4[0].d);
    check("s1.valid", s1.valid, q1.size() != 0);
    check("last1", last1, head_last(q1));
    if (q1.size() != 0) check("s1.data", s1.data, q1[0].d);
    if (!clear) begin
      check("p4.ready", p4.ready, r4);
      check("p1.ready", p1.ready, r1);
    end
    h4 = (q4.size() != 0) && srdy;
    h1 = (q1.size() != 0) && srdy;
    a4 = p4.valid && r4 && !clear;
    a1 = p1.valid && r1 && !clear;
    beat = p4.data;
    @(posedge clk);
    if (clear) begin
      q4.delete();
      q1.delete();
    end else begin
      if (h4) void'(q4.pop_front());
      if (h1) void'(q1.pop_front());
      if (a4) begin
        for (int i = 0; i < 4; i++)
          q4.push_back('{d: beat[i*DW +: DW], l: (i == 3)});
      end
      if (a1) q1.push_back('{d: p1.data, l: 1'b1});
    end
    acc4 = a4;
    acc1 = a1;
    @(negedge clk);
  endtask

  task automatic run(int n);
    repeat (n) begin
      if (rpat.size() != 0) srdy = rpat.pop_front();
      else if (rnd_rdy) srdy = 1'($urandom);
      else srdy = 1'b1;
      p4.valid = (pb4.size() != 0);
      p4.data  = (pb4.size() != 0) ? pb4[0] : '0;
      p1.valid = (pb1.size() != 0);
      p1.data  = (pb1.size() != 0) ? pb1[0] : '0;
      step();
      if (acc4) void'(pb4.pop_front());
      if (acc1) void'(pb1.pop_front());
    end
  endtask

  task automatic reset_mid();
    #3 rst_ni = 1'b0;
    #1;
    check_reset_outs();
    q4.delete();
    q1.delete();
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  initial begin
    p4.valid = 1'b0; p4.data = '0; p4.strb = '1;
    p1.valid = 1'b0; p1.data = '0; p1.strb = '1;
    #1;
    check_reset_outs();
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    check("s4.strb", s4.strb, 4'hF);

    // basic beat
    pb4.push_back({32'hD, 32'hC, 32'hB, 32'hA});
    run(7);

    // backpressure 1,0,0,1,0,1,1 after the accept cycle
    pb4.push_back({32'd4, 32'd3, 32'd2, 32'd1});
    rpat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    run(10);

    // back-to-back beats
    pb4.push_back({32'h14, 32'h13, 32'h12, 32'h11});
    pb4.push_back({32'h24, 32'h23, 32'h22, 32'h21});
    run(12);

    // clear after two words, then a fresh beat
    pb4.push_back({32'h44, 32'h33, 32'h22, 32'h11});
    run(3);
    clear = 1'b1;
    run(1);
    clear = 1'b0;
    pb4.push_back({32'h58, 32'h57, 32'h56, 32'h55});
    run(7);

    // async reset mid-beat
    pb4.push_back({32'h64, 32'h63, 32'h62, 32'h61});
    run(3);
    reset_mid();
    pb4.push_back({32'h74, 32'h73, 32'h72, 32'h71});
    run(7);

    // single tap streaming
    pb1.push_back(32'h5);
    pb1.push_back(32'h6);
    pb1.push_back(32'h7);
    run(5);

    // randomized traffic with backpressure, clears and resets
    rnd_rdy = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (pb4.size() < 2 && $urandom_range(3) == 0)
        pb4.push_back({$urandom, $urandom, $urandom, $urandom});
      if (pb1.size() < 2 && $urandom_range(2) == 0)
        pb1.push_back($urandom);
      clear = ($urandom_range(63) == 0);
      if ($urandom_range(499) == 0) reset_mid();
      else run(1);
    end
    clear = 1'b0;
    rnd_rdy = 1'b0;
    run(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_tap_serializer.md
FIR_TAP_SERIALIZER -- requirements
Module: fir_tap_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of one serial tap word.
REQ-002 SHALL have parameter NB_TAPS, default 2: number of words in one parallel beat; legal values are >= 1.
REQ-003 SHALL have port clk_i, input, 1 bit: clock, rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port clear_i, input, 1 bit: synchronous soft clear.
REQ-006 SHALL have port h_parallel, hwpe_stream_intf_stream.sink, DATA_WIDTH*NB_TAPS bits: packed input taps; word i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port h_serial, hwpe_stream_intf_stream.source, DATA_WIDTH bits: serialized output words.
REQ-008 SHALL have port last_o, output, 1 bit: high while h_serial carries word NB_TAPS-1 of the current beat.

Function
REQ-009 SHALL implement a two-state FSM: IDLE and SERIALIZE.
REQ-010 SHALL drive h_parallel.ready = 1 in IDLE, with no dependency on h_serial.ready.
REQ-011 SHALL, on an h_parallel handshake, capture the whole beat into an internal buffer, set the word counter to 0 and enter SERIALIZE on the next edge.
REQ-012 SHALL drive h_serial.valid = 1 in SERIALIZE and 0 in IDLE.
REQ-013 SHALL drive h_serial.data from buffer[counter], i.e. word 0 first and word NB_TAPS-1 last.
REQ-014 SHALL increment the counter by 1 on each h_serial handshake that is not on the last word.
REQ-015 SHALL keep h_serial.data, valid and last_o stable while valid=1 and ready=0.
REQ-016 SHALL, in SERIALIZE, drive h_parallel.ready = h_serial.ready AND (counter == NB_TAPS-1); this is the only combinational ready path.
REQ-017 SHALL behave as follows on the last-word handshake:
- simultaneous h_parallel handshake: reload the buffer, reset the counter to 0 and stay in SERIALIZE, giving zero bubble cycles;
- otherwise: go to IDLE.
REQ-018 SHALL, for NB_TAPS = 1, treat every word as last, size the counter at least 1 bit wide, and sustain a throughput of one word per cycle.
REQ-019 SHALL output one serial word per cycle at most and one beat per NB_TAPS cycles at most; latency from a parallel handshake to the first h_serial.valid is 1 cycle.
REQ-020 SHALL give clear_i priority over all handshakes in the same cycle: next state IDLE, counter 0, buffer zeroed.
REQ-021 SHALL not take over any beat offered together with clear_i; h_parallel.ready may be 1 in that cycle, but the beat is discarded.
REQ-022 SHALL not alter data or add strobes; h_serial.strb is driven all-ones.

Reset
REQ-023 SHALL, while rst_ni = 0, put the FSM in IDLE, the counter at 0 and the buffer at all-zero.
REQ-024 SHALL, while rst_ni = 0, drive h_serial.valid = 0, last_o = 0 and h_serial.data = 0.
REQ-025 SHALL, on reset mid-beat, drop the words not yet sent; the first output after reset is word 0 of the next accepted beat.

Structure
REQ-026 SHALL take the FSM state enum type fir_ser_state_t (IDLE, SERIALIZE) from fir_package.
REQ-027 SHALL need no sub-module; the counter, buffer and FSM are in-module.
REQ-028 SHALL, in simulation only, assert that h_parallel.DATA_WIDTH == DATA_WIDTH*NB_TAPS and h_serial.DATA_WIDTH == DATA_WIDTH.

Verification
REQ-029 SHALL be covered by these directed scenarios, all with NB_TAPS = 4, DATA_WIDTH = 32 and h_serial.ready tied to 1 unless stated otherwise:
- Basic beat: send one beat {3:0xD,2:0xC,1:0xB,0:0xA} -> h_serial emits 0xA,0xB,0xC,0xD on 4 consecutive cycles starting 1 cycle after the handshake; last_o is high only with 0xD; the block returns to IDLE.
- Backpressure: one beat {3:4,2:3,1:2,0:1}; ready follows the per-cycle pattern 1,0,0,1,0,1,1 -> sequence 1,2,3,4 with no loss or duplication; data stays stable through the stalls; h_parallel.ready = 0 until word 4 is accepted.
- Back-to-back: two beats held valid continuously -> 8 consecutive valid cycles with no bubble; the second beat is accepted in the same cycle as the first beat's last word.
- Clear: assert clear_i after 2 words of beat {..,1:0x22,0:0x11} -> valid drops next cycle and the remaining 2 words never appear; the next beat is emitted from word 0.
- Async reset: pull rst_ni low mid-beat -> valid, last_o and data go to 0 immediately; after release, a new beat serializes correctly.
- NB_TAPS = 1: beats 0x5,0x6,0x7 streamed with ready = 1 -> 3 consecutive words 0x5,0x6,0x7 with last_o = 1 on every one.
